instr_fetch: RTL and testbench



---
 rtl/core_pkg.sv | 21 ++
 rtl/instr_fetch.sv | 122 ++++++++++++
 tb/tb_instr_fetch.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the multicycle RV32I core: word width, the canonical
// NOP encoding and the fetch-stage state encoding.
package core_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  // Byte distance between sequential instructions
  localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_VALID = 3'd2,
    S_FAULT = 3'd3,
    S_IDLE  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC, drives the synchronous instruction ROM, captures the
// returned word and hands it to decode over valid/ready; handles redirects, faults and halt.
module instr_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ROM_AW   = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              fetch_fault,
  input  logic              halt,
  output logic              busy
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_instr_pc;
  logic            r_valid;
  logic            r_fault;
  logic            r_busy;

  logic [XLEN-1:0] w_pc_next;
  logic            w_redirect_ok;
  logic            w_next_in_rom;

  function automatic logic in_rom(input logic [XLEN-1:0] a);
    return (a[XLEN-1:ROM_AW] == '0);
  endfunction

  function automatic logic aligned(input logic [XLEN-1:0] a);
    return (a[1:0] == 2'b00);
  endfunction

  assign w_pc_next     = r_pc + INSTR_BYTES;
  assign w_redirect_ok = aligned(redirect_pc) && in_rom(redirect_pc);
  assign w_next_in_rom = in_rom(w_pc_next);

  // The ROM registers this address, so its data is available while in WAIT
  assign rom_addr    = r_pc[ROM_AW-1:0];
  assign instr_valid = r_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign fetch_fault = r_fault;
  assign busy        = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_instr    <= NOP;
      r_instr_pc <= RESET_PC;
      r_valid    <= 1'b0;
      r_fault    <= 1'b0;
      r_busy     <= 1'b1;
    end else if (redirect_valid) begin
      // Redirect wins over everything, including a same-cycle handshake;
      // returning to REQ drops whatever the ROM is producing for the old PC.
      r_pc    <= redirect_pc;
      r_valid <= 1'b0;
      r_busy  <= 1'b1;
      if (w_redirect_ok) begin
        r_state <= S_REQ;
        r_fault <= 1'b0;
      end else begin
        r_state    <= S_FAULT;
        r_fault    <= 1'b1;
        r_instr_pc <= redirect_pc;
      end
    end else begin
      case (r_state)
        S_REQ: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_instr    <= rom_data;
          r_instr_pc <= r_pc;
          r_valid    <= 1'b1;
          r_state    <= S_VALID;
        end
        S_VALID: begin
          // Without ready the instruction is held and halt is ignored
          if (instr_ready) begin
            r_valid <= 1'b0;
            r_pc    <= w_pc_next;
            if (!w_next_in_rom) begin
              r_state    <= S_FAULT;
              r_fault    <= 1'b1;
              r_instr_pc <= w_pc_next;
            end else if (halt) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_REQ;
            end
          end
        end
        S_FAULT: begin
          r_state <= S_FAULT;
        end
        S_IDLE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_REQ;
          r_valid <= 1'b0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a behavioural ROM, a scoreboard of expected
// deliveries consumed on each accepted handshake, and inline state checks.
module tb_instr_fetch;

  localparam int ROM_AW = 14;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ROM_AW-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              fetch_fault;
  logic              halt;
  logic              busy;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] rom [4096];
  logic [31:0] saved_pc;
  logic [31:0] saved_instr;

  instr_fetch #(.RESET_PC(32'h0000_0000), .ROM_AW(ROM_AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .fetch_fault(fetch_fault),
    .halt(halt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one-cycle read latency
  always @(posedge clk) rom_data <= rom[rom_addr[13:2]];

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0020_0193;
    return 32'hC0DE_0000 | {18'b0, a[13:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.word = rom_word(pc);
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max);
    for (int i = 0; i < max && !instr_valid; i++) step();
    chk("wait_valid", {31'b0, instr_valid}, 32'd1);
  endtask

  task automatic deliver();
    wait_valid(12);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] a);
    redirect_pc    = a;
    redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
  endtask

  // Scoreboard: every accepted handshake must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
      chk("sb_pending", {31'b0, (sb.size() > 0)}, 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_instr_pc", instr_pc, e.pc);
        chk("sb_instr", instr, e.word);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = rom_word(32'(i * 4));
    rst_n          = 1'b0;
    instr_ready    = 1'b1;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    repeat (3) step();
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd1);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_rom_addr", {18'b0, rom_addr}, 32'h0);

    // Release mid-cycle; the next period is cycle 0
    #2 rst_n = 1'b1;
    push(32'h0);
    chk("c0_rom_addr", {18'b0, rom_addr}, 32'h0);
    step();
    chk("c1_valid", {31'b0, instr_valid}, 32'd0);
    step();
    chk("c2_valid", {31'b0, instr_valid}, 32'd1);
    chk("c2_instr", instr, 32'h0020_0193);
    chk("c2_instr_pc", instr_pc, 32'h0);
    step();
    chk("c3_rom_addr", {18'b0, rom_addr}, 32'h4);
    instr_ready = 1'b0;

    // Back-pressure
    push(32'h4);
    wait_valid(12);
    saved_pc    = instr_pc;
    saved_instr = instr;
    repeat (5) step();
    chk("bp_valid", {31'b0, instr_valid}, 32'd1);
    chk("bp_instr_stable", instr, saved_instr);
    chk("bp_pc_stable", instr_pc, saved_pc);
    chk("bp_rom_addr", {18'b0, rom_addr}, 32'h4);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    push(32'h8);
    wait_valid(12);
    chk("bp_next_pc", instr_pc, saved_pc + 32'd4);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;

    // Redirect while in WAIT: the word for pc=0xc must never be delivered
    step();
    redirect(32'h18);
    chk("rw_valid", {31'b0, instr_valid}, 32'd0);
    chk("rw_rom_addr", {18'b0, rom_addr}, 32'h18);
    push(32'h18);
    deliver();

    // Redirect coincident with a handshake of pc=0x1c
    wait_valid(12);
    instr_ready    = 1'b1;
    redirect_pc    = 32'hac;
    redirect_valid = 1'b1;
    step();
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    chk("rh_valid", {31'b0, instr_valid}, 32'd0);
    chk("rh_rom_addr", {18'b0, rom_addr}, 32'hac);
    push(32'hac);
    wait_valid(12);
    chk("rh_instr_pc", instr_pc, 32'hac);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;

    // Misaligned target, then recovery
    redirect(32'h1e);
    chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
    chk("mis_instr_pc", instr_pc, 32'h1e);
    chk("mis_valid", {31'b0, instr_valid}, 32'd0);
    repeat (3) step();
    chk("mis_fault_hold", {31'b0, fetch_fault}, 32'd1);
    chk("mis_valid_hold", {31'b0, instr_valid}, 32'd0);
    redirect(32'h20);
    chk("rec_fault", {31'b0, fetch_fault}, 32'd0);
    push(32'h20);
    deliver();

    // Out-of-range target
    redirect(32'h0001_0000);
    chk("oor_fault", {31'b0, fetch_fault}, 32'd1);
    chk("oor_instr_pc", instr_pc, 32'h0001_0000);

    // Last ROM word: the increment leaves ROM range
    redirect(32'h3ffc);
    chk("last_fault_clear", {31'b0, fetch_fault}, 32'd0);
    push(32'h3ffc);
    deliver();
    chk("wrap_fault", {31'b0, fetch_fault}, 32'd1);
    chk("wrap_instr_pc", instr_pc, 32'h4000);
    chk("wrap_valid", {31'b0, instr_valid}, 32'd0);

    // Halt
    redirect(32'h40);
    push(32'h40);
    wait_valid(12);
    halt = 1'b1;
    repeat (2) step();
    chk("halt_noready_valid", {31'b0, instr_valid}, 32'd1);
    chk("halt_noready_busy", {31'b0, busy}, 32'd1);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_valid", {31'b0, instr_valid}, 32'd0);
    chk("idle_rom_addr", {18'b0, rom_addr}, 32'h44);
    halt = 1'b0;
    repeat (4) step();
    chk("idle_busy_hold", {31'b0, busy}, 32'd0);
    chk("idle_rom_addr_hold", {18'b0, rom_addr}, 32'h44);
    redirect(32'h0);
    chk("resume_busy", {31'b0, busy}, 32'd1);
    push(32'h0);
    deliver();

    // Asynchronous reset in the middle of a fetch
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd1);
    chk("arst_valid", {31'b0, instr_valid}, 32'd0);
    chk("arst_instr", instr, 32'h0000_0013);
    chk("arst_instr_pc", instr_pc, 32'h0);
    chk("arst_rom_addr", {18'b0, rom_addr}, 32'h0);
    step();
    #2 rst_n = 1'b1;
    push(32'h0);
    wait_valid(12);
    chk("arst_first_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;

    repeat (2) step();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
